// File: rtl/serial_adder_pkg.sv
// Shared types for the bit-serial adder: FSM state encoding and default width.
package serial_adder_pkg;

  localparam int DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_adder_if.sv
// Request/result bundle between a requester and the bit-serial adder.
interface serial_adder_if
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (output start, a, b, cin, input busy, done, sum, cout);
  modport slave  (input start, a, b, cin, output busy, done, sum, cout);
endinterface

// File: rtl/serial_adder_full_beh.sv
// Behavioural 1-bit full adder cell; port order sum, cout, a, b, cin.
module full_beh (
  output logic sum,
  output logic cout,
  input  logic a,
  input  logic b,
  input  logic cin
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell, LSB first, carry fed back
// through a flop. Result registers hold until the next completion.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic            clk,
  input  logic            rst_n,
  serial_adder_if.slave   bus
);
  localparam int CNT_W = $clog2(WIDTH);

  state_t             r_state, w_next;
  logic [WIDTH-1:0]   r_a_sr, r_b_sr, r_sum;
  logic [WIDTH-2:0]   r_s_sr;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_carry, r_busy, r_done, r_cout;
  logic               w_sum_bit, w_cout_bit, w_last, w_accept;
  logic [WIDTH-1:0]   w_s_next;

  full_beh u_fa (
    .sum  (w_sum_bit),
    .cout (w_cout_bit),
    .a    (r_a_sr[0]),
    .b    (r_b_sr[0]),
    .cin  (r_carry)
  );

  assign w_accept = (r_state == S_IDLE) && bus.start;
  assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));
  // Newest sum bit enters at the MSB; bit 0 falls out as the shift-register spill.
  assign w_s_next = {w_sum_bit, r_s_sr};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_next = S_RUN;
      S_RUN:   if (w_last)    w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_sr  <= '0;
      r_b_sr  <= '0;
      r_s_sr  <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_a_sr  <= bus.a;
        r_b_sr  <= bus.b;
        r_carry <= bus.cin;
        r_cnt   <= '0;
        r_busy  <= 1'b1;
      end else if (r_state == S_RUN) begin
        r_a_sr  <= {1'b0, r_a_sr[WIDTH-1:1]};
        r_b_sr  <= {1'b0, r_b_sr[WIDTH-1:1]};
        r_s_sr  <= w_s_next[WIDTH-1:1];
        r_carry <= w_cout_bit;
        if (w_last) begin
          r_sum  <= w_s_next;
          r_cout <= w_cout_bit;
          r_done <= 1'b1;
          r_busy <= 1'b0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.sum  = r_sum;
  assign bus.cout = r_cout;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder at WIDTH=8 and WIDTH=2.
module tb_serial_adder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(8)) bus8 ();
  serial_adder_if #(.WIDTH(2)) bus2 ();

  serial_adder #(.WIDTH(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
  serial_adder #(.WIDTH(2)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One WIDTH=8 operation; optionally pulse start with FF operands on RUN cycle inj.
  task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b,
                     input logic c, input logic [7:0] es, input logic ec, input int inj);
    int lat, busy_n;
    @(negedge clk);
    bus8.start = 1'b1; bus8.a = a; bus8.b = b; bus8.cin = c;
    @(negedge clk);
    bus8.start = 1'b0; bus8.a = 8'h00; bus8.b = 8'h00; bus8.cin = 1'b0;
    lat = 0; busy_n = 0;
    while (!bus8.done && lat < 30) begin
      if (bus8.busy) busy_n++;
      if (lat == inj) begin bus8.start = 1'b1; bus8.a = 8'hFF; bus8.b = 8'hFF; end
      else bus8.start = 1'b0;
      @(negedge clk);
      lat++;
    end
    bus8.start = 1'b0;
    chk({tag, "_lat"}, 32'(lat), 32'd8);
    chk({tag, "_busy"}, 32'(busy_n), 32'd8);
    chk({tag, "_sum"}, 32'(bus8.sum), 32'(es));
    chk({tag, "_cout"}, 32'(bus8.cout), 32'(ec));
    @(negedge clk);
    chk({tag, "_pulse"}, 32'(bus8.done), 32'd0);
  endtask

  initial begin
    int dn, lat;
    bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.cin = 1'b0;
    bus2.start = 1'b0; bus2.a = '0; bus2.b = '0; bus2.cin = 1'b0;
    #22;
    chk("rst_busy", 32'(bus8.busy), 32'd0);
    chk("rst_done", 32'(bus8.done), 32'd0);
    chk("rst_sum",  32'(bus8.sum),  32'd0);
    chk("rst_cout", 32'(bus8.cout), 32'd0);
    @(negedge clk); rst_n = 1'b1;

    op8("t1", 8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0, -1);
    op8("t2", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, -1);
    op8("t3a", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, -1);
    op8("t3b", 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, -1);
    op8("t4", 8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 3);
    dn = 0;
    for (int i = 0; i < 12; i++) begin @(negedge clk); if (bus8.done) dn++; end
    chk("t4_extra_done", 32'(dn), 32'd0);

    // Reset mid-RUN; sum must hold 0x30 until then.
    @(negedge clk);
    bus8.start = 1'b1; bus8.a = 8'hAA; bus8.b = 8'h55; bus8.cin = 1'b0;
    @(negedge clk);
    bus8.start = 1'b0;
    dn = 0;
    for (int i = 0; i < 4; i++) begin
      if (bus8.done) dn++;
      if (i == 2) chk("t5_hold", 32'(bus8.sum), 32'h30);
      @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    chk("t5_busy", 32'(bus8.busy), 32'd0);
    chk("t5_done", 32'(bus8.done), 32'd0);
    chk("t5_sum",  32'(bus8.sum),  32'd0);
    chk("t5_cout", 32'(bus8.cout), 32'd0);
    chk("t5_nodone", 32'(dn), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    op8("t5b", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, -1);

    // start held high: accepts every 10 cycles, operands swapped after each capture.
    @(negedge clk);
    bus8.start = 1'b1; bus8.a = 8'd1; bus8.b = 8'd1; bus8.cin = 1'b0;
    for (lat = 0; lat < 30; lat++) begin
      @(negedge clk);
      if (lat % 10 == 0) begin
        chk($sformatf("t6_busy%0d", lat), 32'(bus8.busy), 32'd1);
        bus8.a = 8'(lat / 10 + 2); bus8.b = 8'(lat / 10 + 2);
      end
      if (lat % 10 == 8) begin
        chk($sformatf("t6_done%0d", lat), 32'(bus8.done), 32'd1);
        chk($sformatf("t6_sum%0d", lat), 32'(bus8.sum), 32'(2 * (lat / 10 + 1)));
      end
      if (lat % 10 == 5 && lat >= 10)
        chk($sformatf("t6_hold%0d", lat), 32'(bus8.sum), 32'(2 * (lat / 10)));
      if (lat == 28) bus8.start = 1'b0;
    end

    // WIDTH=2: 3+3+1 = 7
    chk("w2_rst_sum", 32'(bus2.sum), 32'd0);
    @(negedge clk);
    bus2.start = 1'b1; bus2.a = 2'd3; bus2.b = 2'd3; bus2.cin = 1'b1;
    @(negedge clk);
    bus2.start = 1'b0;
    lat = 0;
    while (!bus2.done && lat < 10) begin @(negedge clk); lat++; end
    chk("w2_lat",  32'(lat), 32'd2);
    chk("w2_sum",  32'(bus2.sum), 32'd3);
    chk("w2_cout", 32'(bus2.cout), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
